// File: rtl/ctr_seq_checker.sv
// Self-checking monitor for a modulo-MOD counter: learns the count, locks after LOCK_N good increments, then flags deviations.
// Optional sticky error flag is enabled by defining CTR_CHK_STICKY_EN.
module ctr_seq_checker #(
  parameter int WIDTH     = 4,
  parameter int MOD       = 16,
  parameter int LOCK_N    = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_en,
  input  logic [WIDTH-1:0]     count,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 wrap_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0]     exp_count,
  output logic                 err_sticky
);

  localparam int RUN_W = $clog2(LOCK_N + 1);
  localparam logic [RUN_W-1:0] LOCK_V = RUN_W'(LOCK_N);
  localparam logic [WIDTH:0]   MOD_V  = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(MOD - 1);

  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

  state_t               state, state_n;
  logic [WIDTH-1:0]     prev, prev_n;
  logic [RUN_W-1:0]     run, run_n;
  logic [ERR_CNT_W-1:0] cnt_n;
  logic                 err_n, wrap_n;
  logic                 legal, match;

  // Explicit wrap so a MOD smaller than 2^WIDTH increments correctly.
  function automatic logic [WIDTH-1:0] incr(input logic [WIDTH-1:0] v);
    return (v == LAST_V) ? '0 : v + WIDTH'(1);
  endfunction

  assign legal  = ({1'b0, count} < MOD_V);
  assign match  = legal && (count == incr(prev));
  assign locked = (state == LOCK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      run        <= '0;
      err_cnt    <= '0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      exp_count  <= WIDTH'(1);
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      run        <= run_n;
      err_cnt    <= cnt_n;
      err_pulse  <= err_n;
      wrap_pulse <= wrap_n;
      exp_count  <= incr(prev_n);
    end
  end

  always_comb begin
    state_n = state;
    prev_n  = prev;
    run_n   = run;
    cnt_n   = err_cnt;
    err_n   = 1'b0;
    wrap_n  = 1'b0;
    if (sample_en) begin
      case (state)
        IDLE: begin
          if (legal) begin
            prev_n  = count;
            run_n   = '0;
            state_n = ACQ;
          end
        end
        ACQ: begin
          if (match) begin
            run_n  = run + RUN_W'(1);
            prev_n = count;
            if (run_n == LOCK_V) state_n = LOCK;
          end else begin
            run_n = '0;
            if (legal) prev_n = count;
          end
        end
        LOCK: begin
          if (match) begin
            prev_n = count;
            wrap_n = (count == '0);
          end else begin
            err_n   = 1'b1;
            state_n = ACQ;
            run_n   = '0;
            if (err_cnt != '1) cnt_n = err_cnt + ERR_CNT_W'(1);
            if (legal) prev_n = count;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef CTR_CHK_STICKY_EN
  logic sticky_q;

  // Saturation also latches the flag so a pinned counter is never missed.
  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else if (err_n || (cnt_n == '1)) sticky_q <= 1'b1;
  end

  assign err_sticky = sticky_q;
`else
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_ctr_seq_checker.sv
// Scoreboard bench for ctr_seq_checker: a default instance and a MOD=10 / 2-bit error counter instance share stimulus.
module tb_ctr_seq_checker;

`ifdef CTR_CHK_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_en = 1'b0;
  logic [3:0] count = 4'd0;

  logic       locked_a, err_a, wrap_a, sticky_a;
  logic [7:0] err_cnt_a;
  logic [3:0] exp_a;
  logic       locked_b, err_b, wrap_b, sticky_b;
  logic [1:0] err_cnt_b;
  logic [3:0] exp_b;

  int errors = 0;
  int checks = 0;
  bit sel = 1'b0;

  typedef struct {
    bit          sel;
    logic [15:0] want;
    string       name;
  } entry_t;

  entry_t sbq[$];

  always #5 clk = ~clk;

  ctr_seq_checker dut_a (
    .clk(clk), .rst(rst), .sample_en(sample_en), .count(count),
    .locked(locked_a), .err_pulse(err_a), .wrap_pulse(wrap_a),
    .err_cnt(err_cnt_a), .exp_count(exp_a), .err_sticky(sticky_a)
  );

  ctr_seq_checker #(.WIDTH(4), .MOD(10), .LOCK_N(3), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .sample_en(sample_en), .count(count),
    .locked(locked_b), .err_pulse(err_b), .wrap_pulse(wrap_b),
    .err_cnt(err_cnt_b), .exp_count(exp_b), .err_sticky(sticky_b)
  );

  // Drive one vector at the falling edge and queue what the selected DUT must show after the next rising edge.
  task automatic apply_stimulus(input string name, input logic en, input logic r, input logic [3:0] c,
                                input logic l, input logic e, input logic w, input logic [7:0] ec,
                                input logic [3:0] ex, input logic st);
    entry_t ent;
    @(negedge clk);
    sample_en = en;
    rst       = r;
    count     = c;
    ent.sel   = sel;
    ent.want  = {l, e, w, st & STICKY, ec, ex};
    ent.name  = name;
    sbq.push_back(ent);
  endtask

  task automatic check_output(input entry_t ent);
    logic [15:0] got;
    if (ent.sel)
      got = {locked_b, err_b, wrap_b, sticky_b, 6'd0, err_cnt_b, exp_b};
    else
      got = {locked_a, err_a, wrap_a, sticky_a, err_cnt_a, exp_a};
    checks++;
    if (got !== ent.want) begin
      errors++;
      $display("[TB] FAIL %s dut=%0d got lk/er/wr/st=%b errcnt=%0d exp=%0d, want lk/er/wr/st=%b errcnt=%0d exp=%0d",
               ent.name, ent.sel, got[15:12], got[11:4], got[3:0],
               ent.want[15:12], ent.want[11:4], ent.want[3:0]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) check_output(sbq.pop_front());
    end
  end

  initial begin
    logic [3:0] c;

    sel = 1'b0;
    apply_stimulus("reset", 1, 1, 4'd0, 0, 0, 0, 8'd0, 4'd1, 0);
    for (int i = 0; i < 18; i++) begin
      c = 4'(i % 16);
      apply_stimulus("count_up", 1, 0, c, i >= 3, 0, i == 16, 8'd0, 4'((i + 1) % 16), 0);
    end
    apply_stimulus("pre_skip2", 1, 0, 4'd2, 1, 0, 0, 8'd0, 4'd3, 0);
    apply_stimulus("pre_skip3", 1, 0, 4'd3, 1, 0, 0, 8'd0, 4'd4, 0);
    apply_stimulus("pre_skip4", 1, 0, 4'd4, 1, 0, 0, 8'd0, 4'd5, 0);
    apply_stimulus("skip_to_7", 1, 0, 4'd7, 0, 1, 0, 8'd1, 4'd8, 1);
    apply_stimulus("relock8",   1, 0, 4'd8, 0, 0, 0, 8'd1, 4'd9, 1);
    apply_stimulus("relock9",   1, 0, 4'd9, 0, 0, 0, 8'd1, 4'd10, 1);
    apply_stimulus("relock10",  1, 0, 4'd10, 1, 0, 0, 8'd1, 4'd11, 1);

    apply_stimulus("reset2",    1, 1, 4'd5, 0, 0, 0, 8'd0, 4'd1, 0);
    apply_stimulus("gap_v0",    1, 0, 4'd0, 0, 0, 0, 8'd0, 4'd1, 0);
    apply_stimulus("gap_h0",    0, 0, 4'hA, 0, 0, 0, 8'd0, 4'd1, 0);
    apply_stimulus("gap_v1",    1, 0, 4'd1, 0, 0, 0, 8'd0, 4'd2, 0);
    apply_stimulus("gap_h1",    0, 0, 4'hA, 0, 0, 0, 8'd0, 4'd2, 0);
    apply_stimulus("gap_v2",    1, 0, 4'd2, 0, 0, 0, 8'd0, 4'd3, 0);
    apply_stimulus("gap_h2",    0, 0, 4'hA, 0, 0, 0, 8'd0, 4'd3, 0);
    apply_stimulus("gap_v3",    1, 0, 4'd3, 1, 0, 0, 8'd0, 4'd4, 0);
    apply_stimulus("gap_h3",    0, 0, 4'hA, 1, 0, 0, 8'd0, 4'd4, 0);
    apply_stimulus("stall3",    1, 0, 4'd3, 0, 1, 0, 8'd1, 4'd4, 1);

    apply_stimulus("reset3",    1, 1, 4'd0, 0, 0, 0, 8'd0, 4'd1, 0);
    for (int i = 0; i < 4; i++)
      apply_stimulus("lock_again", 1, 0, 4'(i), i == 3, 0, 0, 8'd0, 4'(i + 1), 0);
    apply_stimulus("rst_vs_err", 1, 1, 4'd9, 0, 0, 0, 8'd0, 4'd1, 0);
    apply_stimulus("idle_acq5",  1, 0, 4'd5, 0, 0, 0, 8'd0, 4'd6, 0);
    apply_stimulus("acq6",       1, 0, 4'd6, 0, 0, 0, 8'd0, 4'd7, 0);
    apply_stimulus("acq7",       1, 0, 4'd7, 0, 0, 0, 8'd0, 4'd8, 0);
    apply_stimulus("acq8_lock",  1, 0, 4'd8, 1, 0, 0, 8'd0, 4'd9, 0);

    sel = 1'b1;
    apply_stimulus("m10_reset", 1, 1, 4'd0, 0, 0, 0, 8'd0, 4'd1, 0);
    for (int i = 0; i < 11; i++) begin
      c = 4'(i % 10);
      apply_stimulus("m10_up", 1, 0, c, i >= 3, 0, i == 10, 8'd0, 4'((i + 1) % 10), 0);
    end
    apply_stimulus("m10_one",   1, 0, 4'd1, 1, 0, 0, 8'd0, 4'd2, 0);
    apply_stimulus("m10_ill12", 1, 0, 4'd12, 0, 1, 0, 8'd1, 4'd2, 1);
    apply_stimulus("m10_r2",    1, 0, 4'd2, 0, 0, 0, 8'd1, 4'd3, 1);
    apply_stimulus("m10_r3",    1, 0, 4'd3, 0, 0, 0, 8'd1, 4'd4, 1);
    apply_stimulus("m10_r4",    1, 0, 4'd4, 1, 0, 0, 8'd1, 4'd5, 1);
    apply_stimulus("m10_err2",  1, 0, 4'd4, 0, 1, 0, 8'd2, 4'd5, 1);
    apply_stimulus("m10_r5",    1, 0, 4'd5, 0, 0, 0, 8'd2, 4'd6, 1);
    apply_stimulus("m10_r6",    1, 0, 4'd6, 0, 0, 0, 8'd2, 4'd7, 1);
    apply_stimulus("m10_r7",    1, 0, 4'd7, 1, 0, 0, 8'd2, 4'd8, 1);
    apply_stimulus("m10_err3",  1, 0, 4'd0, 0, 1, 0, 8'd3, 4'd1, 1);
    apply_stimulus("m10_s1",    1, 0, 4'd1, 0, 0, 0, 8'd3, 4'd2, 1);
    apply_stimulus("m10_s2",    1, 0, 4'd2, 0, 0, 0, 8'd3, 4'd3, 1);
    apply_stimulus("m10_s3",    1, 0, 4'd3, 1, 0, 0, 8'd3, 4'd4, 1);
    apply_stimulus("m10_sat_a", 1, 0, 4'd15, 0, 1, 0, 8'd3, 4'd4, 1);
    apply_stimulus("m10_t4",    1, 0, 4'd4, 0, 0, 0, 8'd3, 4'd5, 1);
    apply_stimulus("m10_t5",    1, 0, 4'd5, 0, 0, 0, 8'd3, 4'd6, 1);
    apply_stimulus("m10_t6",    1, 0, 4'd6, 1, 0, 0, 8'd3, 4'd7, 1);
    apply_stimulus("m10_sat_b", 1, 0, 4'd6, 0, 1, 0, 8'd3, 4'd7, 1);
    apply_stimulus("m10_reset2", 1, 1, 4'd6, 0, 0, 0, 8'd0, 4'd1, 0);
    apply_stimulus("m10_idle_ill", 1, 0, 4'd13, 0, 0, 0, 8'd0, 4'd1, 0);
    apply_stimulus("m10_idle_5",   1, 0, 4'd5, 0, 0, 0, 8'd0, 4'd6, 0);

    @(negedge clk);
    sample_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d want=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
